vmem_blitter: RTL and testbench

//  Rectangle fill/copy engine for video memory. CPU programs it via memory-mapped registers (top decodes 65024-65033).

---
 rtl/vmem_blitter_pkg.sv | 34 +++
 rtl/vmem_blitter_if.sv | 22 ++
 rtl/vmem_blitter_addrgen.sv | 66 ++++++
 rtl/vmem_blitter.sv | 190 +++++++++++++++++++
 tb/tb_vmem_blitter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vmem_blitter_pkg.sv
// Shared definitions for the video memory blitter: register map, CTRL/STATUS bits, FSM states.
package vmem_blitter_pkg;

   localparam logic [3:0] REG_SRC_LO = 4'd0;
   localparam logic [3:0] REG_SRC_HI = 4'd1;
   localparam logic [3:0] REG_DST_LO = 4'd2;
   localparam logic [3:0] REG_DST_HI = 4'd3;
   localparam logic [3:0] REG_WIDTH  = 4'd4;
   localparam logic [3:0] REG_HEIGHT = 4'd5;
   localparam logic [3:0] REG_STRIDE = 4'd6;
   localparam logic [3:0] REG_FILL   = 4'd7;
   localparam logic [3:0] REG_CTRL   = 4'd8;
   localparam logic [3:0] REG_STATUS = 4'd9;

   localparam int CTRL_START  = 0;
   localparam int CTRL_MODE   = 1;
   localparam int CTRL_IRQ_EN = 2;
   localparam int CTRL_ABORT  = 7;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_ABORTED = 2;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_RD   = 3'd2,
      S_RDW  = 3'd3,
      S_WR   = 3'd4,
      S_ADV  = 3'd5,
      S_DONE = 3'd6
   } state_e;

endpackage

// File: rtl/vmem_blitter_if.sv
// Video memory port A request/grant bus between the blitter (master) and the memory/arbiter (slave).
interface vmem_blitter_if #(
   parameter int AW = 16,
   parameter int DW = 8
);
   logic          dma_req;
   logic          dma_grant;
   logic [AW-1:0] dma_addr;
   logic          dma_we;
   logic [DW-1:0] dma_wdata;
   logic [DW-1:0] dma_rdata;

   modport master (
      output dma_req, dma_addr, dma_we, dma_wdata,
      input  dma_grant, dma_rdata
   );

   modport slave (
      input  dma_req, dma_addr, dma_we, dma_wdata,
      output dma_grant, dma_rdata
   );
endinterface

// File: rtl/vmem_blitter_addrgen.sv
// Rectangle walker: column/row counters, source/destination row bases stepped by stride.
module vmem_blitter_addrgen #(
   parameter int AW    = 16,
   parameter int DIM_W = 8
) (
   input  logic             clkCPU,
   input  logic             reset,
   input  logic             load_i,
   input  logic             adv_i,
   input  logic [AW-1:0]    src_i,
   input  logic [AW-1:0]    dst_i,
   input  logic [DIM_W-1:0] width_i,
   input  logic [DIM_W-1:0] height_i,
   input  logic [DIM_W-1:0] stride_i,
   output logic [AW-1:0]    src_addr_o,
   output logic [AW-1:0]    dst_addr_o,
   output logic             empty_o,
   output logic             end_o
);

   logic [AW-1:0]    src_base_q, dst_base_q;
   logic [DIM_W-1:0] width_q, height_q, stride_q, col_q, row_q;
   logic             end_q;
   logic             last_col, last_row;

   assign last_col   = (col_q == width_q - DIM_W'(1));
   assign last_row   = (row_q == height_q - DIM_W'(1));
   assign src_addr_o = src_base_q + AW'(col_q);
   assign dst_addr_o = dst_base_q + AW'(col_q);
   assign empty_o    = (width_q == '0) || (height_q == '0);
   assign end_o      = end_q;

   always_ff @(posedge clkCPU or posedge reset) begin
      if (reset) begin
         src_base_q <= '0;
         dst_base_q <= '0;
         width_q    <= '0;
         height_q   <= '0;
         stride_q   <= '0;
         col_q      <= '0;
         row_q      <= '0;
         end_q      <= 1'b0;
      end else if (load_i) begin
         src_base_q <= src_i;
         dst_base_q <= dst_i;
         width_q    <= width_i;
         height_q   <= height_i;
         stride_q   <= stride_i;
         col_q      <= '0;
         row_q      <= '0;
         end_q      <= 1'b0;
      end else if (adv_i) begin
         // End of row: wrap the column and step both row bases by the zero-extended stride.
         if (last_col) begin
            col_q      <= '0;
            row_q      <= row_q + DIM_W'(1);
            src_base_q <= src_base_q + AW'(stride_q);
            dst_base_q <= dst_base_q + AW'(stride_q);
            if (last_row) end_q <= 1'b1;
         end else begin
            col_q <= col_q + DIM_W'(1);
         end
      end
   end

endmodule

// File: rtl/vmem_blitter.sv
// Rectangle fill/copy engine sharing video memory port A with the CPU; register file and sequencing FSM.
// state | meaning
// IDLE  | waiting for CTRL.start
// LOAD  | geometry latched, zero-size check
// RD    | source read requested, held until granted
// RDW   | read data returned and captured
// WR    | destination write requested, held until granted
// ADV   | addresses stepped, last-element test
// DONE  | sets done, returns to IDLE
module vmem_blitter
   import vmem_blitter_pkg::*;
#(
   parameter int AW    = 16,
   parameter int DW    = 8,
   parameter int DIM_W = 8
) (
   input  logic           clkCPU,
   input  logic           reset,
   input  logic           reg_we_i,
   input  logic [3:0]     reg_sel_i,
   input  logic [7:0]     reg_wdata_i,
   output logic [7:0]     reg_rdata_o,
   output logic           busy_o,
   output logic           irq_o,
   vmem_blitter_if.master dma_if
);

   state_e           state_q;
   logic [7:0]       src_lo_q, src_hi_q, dst_lo_q, dst_hi_q, fill_q;
   logic [DIM_W-1:0] width_q, height_q, stride_q;
   logic             mode_q, irq_en_q, done_q, aborted_q, busy_q;
   logic             dma_req_q, dma_we_q;
   logic [AW-1:0]    dma_addr_q;
   logic [DW-1:0]    dma_wdata_q;

   logic             ctrl_wr, start_req, abort_req;
   logic [AW-1:0]    ag_src, ag_dst;
   logic             ag_empty, ag_end;

   assign ctrl_wr   = reg_we_i && (reg_sel_i == REG_CTRL);
   assign start_req = ctrl_wr && reg_wdata_i[CTRL_START] && !reg_wdata_i[CTRL_ABORT] && (state_q == S_IDLE);
   assign abort_req = ctrl_wr && reg_wdata_i[CTRL_ABORT] && (state_q != S_IDLE);

   vmem_blitter_addrgen #(.AW(AW), .DIM_W(DIM_W)) u_addrgen (
      .clkCPU     (clkCPU),
      .reset      (reset),
      .load_i     (start_req),
      .adv_i      ((state_q == S_WR) && dma_if.dma_grant),
      .src_i      (AW'({src_hi_q, src_lo_q})),
      .dst_i      (AW'({dst_hi_q, dst_lo_q})),
      .width_i    (width_q),
      .height_i   (height_q),
      .stride_i   (stride_q),
      .src_addr_o (ag_src),
      .dst_addr_o (ag_dst),
      .empty_o    (ag_empty),
      .end_o      (ag_end)
   );

   always_comb begin
      reg_rdata_o = '0;
      case (reg_sel_i)
         REG_SRC_LO: reg_rdata_o = src_lo_q;
         REG_SRC_HI: reg_rdata_o = src_hi_q;
         REG_DST_LO: reg_rdata_o = dst_lo_q;
         REG_DST_HI: reg_rdata_o = dst_hi_q;
         REG_WIDTH:  reg_rdata_o = 8'(width_q);
         REG_HEIGHT: reg_rdata_o = 8'(height_q);
         REG_STRIDE: reg_rdata_o = 8'(stride_q);
         REG_FILL:   reg_rdata_o = fill_q;
         REG_CTRL: begin
            reg_rdata_o[CTRL_MODE]   = mode_q;
            reg_rdata_o[CTRL_IRQ_EN] = irq_en_q;
         end
         REG_STATUS: begin
            reg_rdata_o[STAT_BUSY]    = busy_q;
            reg_rdata_o[STAT_DONE]    = done_q;
            reg_rdata_o[STAT_ABORTED] = aborted_q;
         end
         default: reg_rdata_o = '0;
      endcase
   end

   always_ff @(posedge clkCPU or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         src_lo_q    <= '0;
         src_hi_q    <= '0;
         dst_lo_q    <= '0;
         dst_hi_q    <= '0;
         width_q     <= '0;
         height_q    <= '0;
         stride_q    <= '0;
         fill_q      <= '0;
         mode_q      <= 1'b0;
         irq_en_q    <= 1'b0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
         busy_q      <= 1'b0;
         dma_req_q   <= 1'b0;
         dma_we_q    <= 1'b0;
         dma_addr_q  <= '0;
         dma_wdata_q <= '0;
      end else begin
         if (reg_we_i && !busy_q) begin
            case (reg_sel_i)
               REG_SRC_LO: src_lo_q <= reg_wdata_i;
               REG_SRC_HI: src_hi_q <= reg_wdata_i;
               REG_DST_LO: dst_lo_q <= reg_wdata_i;
               REG_DST_HI: dst_hi_q <= reg_wdata_i;
               REG_WIDTH:  width_q  <= DIM_W'(reg_wdata_i);
               REG_HEIGHT: height_q <= DIM_W'(reg_wdata_i);
               REG_STRIDE: stride_q <= DIM_W'(reg_wdata_i);
               REG_FILL:   fill_q   <= reg_wdata_i;
               REG_CTRL: begin
                  mode_q   <= reg_wdata_i[CTRL_MODE];
                  irq_en_q <= reg_wdata_i[CTRL_IRQ_EN];
               end
               default: ;
            endcase
         end
         if (reg_we_i && (reg_sel_i == REG_STATUS)) begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
         end

         case (state_q)
            S_IDLE: if (start_req) begin
               state_q <= S_LOAD;
               busy_q  <= 1'b1;
            end
            S_LOAD, S_ADV: begin
               if ((state_q == S_LOAD) ? ag_empty : ag_end) begin
                  state_q <= S_DONE;
               end else if (mode_q) begin
                  state_q    <= S_RD;
                  dma_req_q  <= 1'b1;
                  dma_we_q   <= 1'b0;
                  dma_addr_q <= ag_src;
               end else begin
                  state_q     <= S_WR;
                  dma_req_q   <= 1'b1;
                  dma_we_q    <= 1'b1;
                  dma_addr_q  <= ag_dst;
                  dma_wdata_q <= DW'(fill_q);
               end
            end
            S_RD: if (dma_if.dma_grant) begin
               state_q   <= S_RDW;
               dma_req_q <= 1'b0;
            end
            S_RDW: begin
               state_q     <= S_WR;
               dma_req_q   <= 1'b1;
               dma_we_q    <= 1'b1;
               dma_addr_q  <= ag_dst;
               dma_wdata_q <= dma_if.dma_rdata;
            end
            S_WR: if (dma_if.dma_grant) begin
               state_q   <= S_ADV;
               dma_req_q <= 1'b0;
               dma_we_q  <= 1'b0;
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase

         // Abort overrides whatever the FSM chose; a write granted this cycle has already happened.
         if (abort_req) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            dma_req_q <= 1'b0;
            dma_we_q  <= 1'b0;
            aborted_q <= 1'b1;
         end
      end
   end

   assign dma_if.dma_req   = dma_req_q;
   assign dma_if.dma_we    = dma_we_q;
   assign dma_if.dma_addr  = dma_addr_q;
   assign dma_if.dma_wdata = dma_wdata_q;
   assign busy_o           = busy_q;
   assign irq_o            = done_q & irq_en_q;

endmodule

// File: tb/tb_vmem_blitter.sv
// Bench for vmem_blitter: table of rectangle ops plus random ops against a write-list model, then abort/reset sequences.
module tb_vmem_blitter;
   import vmem_blitter_pkg::*;

   logic       clkCPU = 1'b0;
   logic       reset  = 1'b1;
   logic       reg_we = 1'b0;
   logic [3:0] reg_sel = '0;
   logic [7:0] reg_wdata = '0;
   logic [7:0] reg_rdata;
   logic       busy, irq;

   vmem_blitter_if #(.AW(16), .DW(8)) dma_bus ();

   vmem_blitter dut (
      .clkCPU      (clkCPU),
      .reset       (reset),
      .reg_we_i    (reg_we),
      .reg_sel_i   (reg_sel),
      .reg_wdata_i (reg_wdata),
      .reg_rdata_o (reg_rdata),
      .busy_o      (busy),
      .irq_o       (irq),
      .dma_if      (dma_bus)
   );

   always #5 clkCPU = ~clkCPU;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   typedef struct {
      bit          copy;
      bit          irq_en;
      logic [15:0] src;
      logic [15:0] dst;
      int          w;
      int          h;
      int          stride;
      logic [7:0]  fill;
      int          gpct;
      int          exp_writes;
      int          exp_busy;
   } vec_t;

   logic [7:0] mem [0:65535];
   wr_t        wlog[$];
   wr_t        exp_log[$];
   int         grant_pct = 100;
   int         req_cycles = 0;
   int         stall_viol = 0;
   int         n_tests = 0;
   int         n_fail = 0;
   logic       prev_stall = 1'b0;
   logic [15:0] prev_addr = '0;
   logic       prev_we = 1'b0;
   logic [7:0] prev_wd = '0;

   always @(negedge clkCPU) dma_bus.dma_grant = ($urandom_range(99) < grant_pct);

   // Memory behind port A: granted writes land in mem and the log, granted reads return data next cycle.
   always @(posedge clkCPU) begin
      if (prev_stall && !reset) begin
         if (dma_bus.dma_req !== 1'b1 || dma_bus.dma_addr !== prev_addr ||
             dma_bus.dma_we !== prev_we || dma_bus.dma_wdata !== prev_wd)
            stall_viol++;
      end
      prev_stall = dma_bus.dma_req && !dma_bus.dma_grant;
      prev_addr  = dma_bus.dma_addr;
      prev_we    = dma_bus.dma_we;
      prev_wd    = dma_bus.dma_wdata;
      if (dma_bus.dma_req) req_cycles++;
      if (dma_bus.dma_req && dma_bus.dma_grant) begin
         if (dma_bus.dma_we) begin
            wr_t e;
            e.addr = dma_bus.dma_addr;
            e.data = dma_bus.dma_wdata;
            mem[dma_bus.dma_addr] = dma_bus.dma_wdata;
            wlog.push_back(e);
         end else begin
            dma_bus.dma_rdata <= mem[dma_bus.dma_addr];
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic wr(input logic [3:0] s, input logic [7:0] d);
      reg_we = 1'b1;
      reg_sel = s;
      reg_wdata = d;
      @(negedge clkCPU);
      reg_we = 1'b0;
   endtask

   task automatic rd(input logic [3:0] s, output logic [7:0] d);
      reg_sel = s;
      #1;
      d = reg_rdata;
      @(negedge clkCPU);
   endtask

   task automatic prog(input logic [15:0] src, input logic [15:0] dst, input logic [7:0] w,
                       input logic [7:0] h, input logic [7:0] stride, input logic [7:0] fill);
      wr(REG_SRC_LO, src[7:0]);
      wr(REG_SRC_HI, src[15:8]);
      wr(REG_DST_LO, dst[7:0]);
      wr(REG_DST_HI, dst[15:8]);
      wr(REG_WIDTH, w);
      wr(REG_HEIGHT, h);
      wr(REG_STRIDE, stride);
      wr(REG_FILL, fill);
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int cyc;
      int req0;
      int nbad;
      logic [7:0] st;
      grant_pct = v.gpct;
      if (v.copy)
         for (int r = 0; r < v.h; r++)
            for (int c = 0; c < v.w; c++)
               mem[16'(int'(v.src) + r * v.stride + c)] = 8'(1 + c + 37 * r);
      // Expected write list: row-major walk, address = base + row*stride + col, modulo 64K.
      exp_log.delete();
      for (int r = 0; r < v.h; r++)
         for (int c = 0; c < v.w; c++) begin
            wr_t e;
            e.addr = 16'(int'(v.dst) + r * v.stride + c);
            e.data = v.copy ? mem[16'(int'(v.src) + r * v.stride + c)] : v.fill;
            exp_log.push_back(e);
         end
      prog(v.src, v.dst, 8'(v.w), 8'(v.h), 8'(v.stride), v.fill);
      wlog.delete();
      req0 = req_cycles;
      wr(REG_CTRL, {5'b0, v.irq_en, v.copy, 1'b1});
      cyc = 0;
      while (busy === 1'b1 && cyc < 5000) begin
         cyc++;
         @(negedge clkCPU);
      end
      check({nm, " finished"}, 32'(cyc < 5000), 32'd1);
      if (v.exp_busy != 0) check({nm, " busy_cycles"}, cyc, v.exp_busy);
      if (v.exp_writes == 0) check({nm, " req_cycles"}, req_cycles - req0, 0);
      check({nm, " write_count"}, wlog.size(), v.exp_writes);
      nbad = 0;
      for (int i = 0; i < exp_log.size(); i++)
         if (i >= wlog.size() || wlog[i].addr !== exp_log[i].addr || wlog[i].data !== exp_log[i].data)
            nbad++;
      check({nm, " write_mismatches"}, nbad, 0);
      rd(REG_STATUS, st);
      check({nm, " status_done"}, st, 8'h02);
      check({nm, " irq"}, irq, v.irq_en);
      wr(REG_STATUS, 8'h00);
      rd(REG_STATUS, st);
      check({nm, " status_cleared"}, st, 8'h00);
      check({nm, " irq_cleared"}, irq, 1'b0);
   endtask

   initial begin
      vec_t       vecs[8];
      vec_t       v;
      logic [7:0] d, pat;
      int         cyc, req0, n0;

      vecs[0] = '{0, 0, 16'h0000, 16'hB100, 4, 2, 160, 8'h41, 100, 8, 18};
      vecs[1] = '{1, 1, 16'h4B00, 16'h5000, 3, 1, 0, 8'h00, 100, 3, 0};
      vecs[2] = '{0, 0, 16'h0000, 16'h7000, 16, 1, 0, 8'h5A, 50, 16, 0};
      vecs[3] = '{0, 0, 16'h0000, 16'hFFFE, 4, 1, 0, 8'h55, 100, 4, 10};
      vecs[4] = '{0, 1, 16'h0000, 16'h1234, 0, 3, 7, 8'h11, 100, 0, 2};
      vecs[5] = '{0, 0, 16'h0000, 16'h1234, 3, 0, 7, 8'h22, 100, 0, 2};
      vecs[6] = '{1, 0, 16'h2000, 16'h3000, 5, 3, 40, 8'h00, 50, 15, 0};
      vecs[7] = '{0, 1, 16'h0000, 16'hA000, 6, 3, 2, 8'h33, 100, 18, 38};

      repeat (3) @(negedge clkCPU);
      reset = 1'b0;
      @(negedge clkCPU);
      check("reset busy", busy, 1'b0);
      check("reset irq", irq, 1'b0);
      check("reset dma_req", dma_bus.dma_req, 1'b0);
      check("reset dma_we", dma_bus.dma_we, 1'b0);
      check("reset dma_addr", dma_bus.dma_addr, 16'h0000);
      check("reset dma_wdata", dma_bus.dma_wdata, 8'h00);
      for (int s = 0; s < 10; s++) begin
         rd(4'(s), d);
         check($sformatf("reset reg%0d", s), d, 8'h00);
      end

      for (int s = 0; s < 8; s++) begin
         pat = 8'($urandom);
         wr(4'(s), pat);
         rd(4'(s), d);
         check($sformatf("readback reg%0d", s), d, pat);
      end
      wr(REG_CTRL, 8'h86);
      rd(REG_CTRL, d);
      check("ctrl readback masks abort", d, 8'h06);
      req0 = req_cycles;
      wr(REG_CTRL, 8'h81);
      @(negedge clkCPU);
      check("start+abort no busy", busy, 1'b0);
      check("start+abort no req", req_cycles - req0, 0);
      rd(REG_CTRL, d);
      check("ctrl readback masks start", d, 8'h00);

      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 6; i++) begin
         v.copy       = 1'($urandom_range(1));
         v.irq_en     = 1'($urandom_range(1));
         v.w          = int'($urandom_range(1, 8));
         v.h          = int'($urandom_range(1, 4));
         v.stride     = int'($urandom_range(255));
         v.src        = 16'($urandom_range(16'h3FFF));
         v.dst        = 16'(32'h8000 + $urandom_range(16'h3FFF));
         v.fill       = 8'($urandom);
         v.gpct       = ($urandom_range(1) == 1) ? 100 : int'($urandom_range(30, 90));
         v.exp_writes = v.w * v.h;
         v.exp_busy   = (!v.copy && v.gpct == 100) ? 2 + 2 * v.w * v.h : 0;
         run_vec(v, $sformatf("rand%0d", i));
      end

      // Abort after the third write of a 10-byte fill; busy-time register writes must be ignored.
      grant_pct = 100;
      prog(16'h0000, 16'h6000, 8'd10, 8'd1, 8'd0, 8'h77);
      wlog.delete();
      wr(REG_CTRL, 8'h01);
      wr(REG_WIDTH, 8'h02);
      wr(REG_CTRL, 8'h01);
      cyc = 0;
      while (wlog.size() < 3 && cyc < 200) begin
         cyc++;
         @(negedge clkCPU);
      end
      check("abort third write seen", wlog.size(), 3);
      wr(REG_CTRL, 8'h80);
      check("abort dma_req drops", dma_bus.dma_req, 1'b0);
      check("abort busy drops", busy, 1'b0);
      repeat (4) @(negedge clkCPU);
      check("abort no more writes", wlog.size(), 3);
      if (wlog.size() >= 3) check("abort third addr", wlog[2].addr, 16'h6002);
      rd(REG_STATUS, d);
      check("abort status", d, 8'h04);
      rd(REG_WIDTH, d);
      check("width write ignored while busy", d, 8'h0A);
      wr(REG_STATUS, 8'h00);

      // Asynchronous reset in the middle of a copy.
      prog(16'h1000, 16'h9000, 8'd8, 8'd2, 8'd16, 8'h00);
      wlog.delete();
      wr(REG_CTRL, 8'h07);
      repeat (7) @(negedge clkCPU);
      check("pre-reset busy", busy, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("mid reset dma_req", dma_bus.dma_req, 1'b0);
      check("mid reset dma_we", dma_bus.dma_we, 1'b0);
      check("mid reset dma_addr", dma_bus.dma_addr, 16'h0000);
      check("mid reset dma_wdata", dma_bus.dma_wdata, 8'h00);
      check("mid reset busy", busy, 1'b0);
      check("mid reset irq", irq, 1'b0);
      req0 = req_cycles;
      n0 = wlog.size();
      @(negedge clkCPU);
      @(negedge clkCPU);
      reset = 1'b0;
      repeat (5) @(negedge clkCPU);
      check("post reset no req", req_cycles - req0, 0);
      check("post reset no writes", wlog.size(), n0);
      rd(REG_WIDTH, d);
      check("post reset width", d, 8'h00);
      rd(REG_CTRL, d);
      check("post reset ctrl", d, 8'h00);

      check("stall outputs stable", stall_viol, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
